// File: rtl/cpu_pkg.sv
// cpu_pkg: shared encodings for the ARM-subset control path.
//   op_t        instruction class from Op[27:26]
//   cond_t      condition field encodings (1111 is deliberately absent: never executes)
//   alu_ctrl_t  ALUControl encodings driven to the datapath
//   CMD_*       data-processing cmd field (Funct[4:1]) values
//   IMM_SRC_*   extend-unit select encodings
package cpu_pkg;

    typedef enum logic [1:0] {
        OP_DP  = 2'b00,
        OP_MEM = 2'b01,
        OP_BR  = 2'b10
    } op_t;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110
    } cond_t;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_ORR = 2'b11
    } alu_ctrl_t;

    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_CMP = 4'b1010;

    localparam logic [1:0] IMM_SRC_8  = 2'b00;
    localparam logic [1:0] IMM_SRC_12 = 2'b01;
    localparam logic [1:0] IMM_SRC_24 = 2'b10;

endpackage : cpu_pkg

// File: rtl/cond_logic.sv
// cond_logic: NZCV flag state, condition evaluation and write qualification.
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset, clears all four flags
//   cond_i       instruction condition field
//   alu_flags_i  {N,Z,C,V} produced by the datapath ALU this cycle
//   flag_w_i     [1] enables N/Z update, [0] enables C/V update
//   pcs_i        unqualified PC write request
//   reg_w_i      unqualified register write request
//   mem_w_i      unqualified memory write request
//   pc_src_o     qualified PC write
//   reg_write_o  qualified register write
//   mem_write_o  qualified memory write
module cond_logic
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] cond_i,
    input  logic [3:0] alu_flags_i,
    input  logic [1:0] flag_w_i,
    input  logic       pcs_i,
    input  logic       reg_w_i,
    input  logic       mem_w_i,
    output logic       pc_src_o,
    output logic       reg_write_o,
    output logic       mem_write_o
);

    logic [1:0] flags_nz_q, flags_nz_d;
    logic [1:0] flags_cv_q, flags_cv_d;
    logic       cond_ex;
    logic       n, z, c, v;

    assign {n, z} = flags_nz_q;
    assign {c, v} = flags_cv_q;

    // Condition is judged on the registered flags only, so an instruction
    // never observes the flags it is itself producing.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        cond_ex = 1'b0;
        case (cond_i)
            COND_EQ: cond_ex = z;
            COND_NE: cond_ex = ~z;
            COND_CS: cond_ex = c;
            COND_CC: cond_ex = ~c;
            COND_MI: cond_ex = n;
            COND_PL: cond_ex = ~n;
            COND_VS: cond_ex = v;
            COND_VC: cond_ex = ~v;
            COND_HI: cond_ex = c & ~z;
            COND_LS: cond_ex = ~c | z;
            COND_GE: cond_ex = (n == v);
            COND_LT: cond_ex = (n != v);
            COND_GT: cond_ex = ~z & (n == v);
            COND_LE: cond_ex = z | (n != v);
            COND_AL: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    // N/Z and C/V are split so logic ops can update N/Z while C/V hold.
    always_comb begin
        flags_nz_d = flags_nz_q;
        flags_cv_d = flags_cv_q;
        if (flag_w_i[1] && cond_ex) flags_nz_d = alu_flags_i[3:2];
        if (flag_w_i[0] && cond_ex) flags_cv_d = alu_flags_i[1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_nz_q <= 2'b00;
            flags_cv_q <= 2'b00;
        end else begin
            // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
            flags_nz_q <= flags_nz_d;
            flags_cv_q <= flags_cv_d;
        end
    end

    assign pc_src_o    = pcs_i   & cond_ex;
    assign reg_write_o = reg_w_i & cond_ex;
    assign mem_write_o = mem_w_i & cond_ex;

endmodule : cond_logic

// File: rtl/control_unit.sv
// control_unit: single-cycle ARM-subset decoder plus condition/flag unit.
//   clk         rising-edge clock
//   reset       asynchronous active-low reset, clears the flag registers
//   Instr       instruction bits [31:12]
//   ALUFlags    {N,Z,C,V} from the datapath ALU
//   RegSrc      [0] RA1 = R15, [1] RA2 = Rd
//   RegWrite    qualified register file write enable
//   ImmSrc      extend select (imm8 / imm12 / imm24)
//   ALUSrc      1: SrcB = ExtImm
//   ALUControl  ADD / SUB / AND / ORR
//   MemtoReg    1: Result = ReadData
//   MemWrite    qualified data memory write enable
//   PCSrc       qualified PC write (PCNext = Result)
module control_unit
    import cpu_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic [31:12] Instr,
    input  logic [3:0]   ALUFlags,
    output logic [1:0]   RegSrc,
    output logic         RegWrite,
    output logic [1:0]   ImmSrc,
    output logic         ALUSrc,
    output logic [1:0]   ALUControl,
    output logic         MemtoReg,
    output logic         MemWrite,
    output logic         PCSrc
);

    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic       unused_rn;

    assign cond      = Instr[31:28];
    assign op        = Instr[27:26];
    assign funct     = Instr[25:20];
    assign rd        = Instr[15:12];
    assign unused_rn = ^Instr[19:16];

    logic       branch, main_reg_w, mem_w, alu_op;
    logic       reg_w, pcs;
    logic [1:0] flag_w;
    alu_ctrl_t  alu_ctrl;

    // Main decode by instruction class.
    always_comb begin
        RegSrc     = 2'b00;
        ImmSrc     = IMM_SRC_8;
        ALUSrc     = 1'b0;
        MemtoReg   = 1'b0;
        main_reg_w = 1'b0;
        mem_w      = 1'b0;
        branch     = 1'b0;
        alu_op     = 1'b0;
        case (op)
            OP_DP: begin
                ALUSrc     = funct[5];
                main_reg_w = 1'b1;
                alu_op     = 1'b1;
            end
            OP_MEM: begin
                ImmSrc = IMM_SRC_12;
                ALUSrc = 1'b1;
                if (funct[0]) begin
                    MemtoReg   = 1'b1;
                    main_reg_w = 1'b1;
                end else begin
                    // Stores read the data register through RA2.
                    RegSrc = 2'b10;
                    mem_w  = 1'b1;
                end
            end
            OP_BR: begin
                // Branch target is PC-relative, so RA1 reads R15.
                RegSrc = 2'b01;
                ImmSrc = IMM_SRC_24;
                ALUSrc = 1'b1;
                branch = 1'b1;
            end
            default: ;
        endcase
    end

    // ALU decode; also where CMP and unsupported cmds suppress the register write.
    always_comb begin
        alu_ctrl = ALU_ADD;
        flag_w   = 2'b00;
        reg_w    = main_reg_w;
        if (alu_op) begin
            case (funct[4:1])
                CMD_ADD: alu_ctrl = ALU_ADD;
                CMD_SUB: alu_ctrl = ALU_SUB;
                CMD_AND: alu_ctrl = ALU_AND;
                CMD_ORR: alu_ctrl = ALU_ORR;
                CMD_CMP: alu_ctrl = ALU_SUB;
                default: alu_ctrl = ALU_ADD;
            endcase

            // C/V are only meaningful for arithmetic results.
            flag_w[1] = funct[0];
            flag_w[0] = funct[0] & ((alu_ctrl == ALU_ADD) || (alu_ctrl == ALU_SUB));

            if (funct[4:1] == CMD_CMP) begin
                reg_w  = 1'b0;
                flag_w = 2'b11;
            end else if ((funct[4:1] != CMD_ADD) && (funct[4:1] != CMD_SUB) &&
                         (funct[4:1] != CMD_AND) && (funct[4:1] != CMD_ORR)) begin
                reg_w  = 1'b0;
                flag_w = 2'b00;
            end
        end
    end

    assign ALUControl = alu_ctrl;

    // A register write to R15 is a PC write.
    assign pcs = branch | (reg_w & (rd == 4'hF));

    cond_logic u_cond_logic (
        .clk         (clk),
        .rst_n       (reset),
        .cond_i      (cond),
        .alu_flags_i (ALUFlags),
        .flag_w_i    (flag_w),
        .pcs_i       (pcs),
        .reg_w_i     (reg_w),
        .mem_w_i     (mem_w),
        .pc_src_o    (PCSrc),
        .reg_write_o (RegWrite),
        .mem_write_o (MemWrite)
    );

endmodule : control_unit

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit. Stimulus drives one instruction per
// cycle just after the rising edge and queues the hand-computed outputs;
// the monitor pops and compares on the falling edge.
// Expected vector packing: {RegSrc, RegWrite, ImmSrc, ALUSrc, ALUControl, MemtoReg, MemWrite, PCSrc}
module tb_control_unit;

    logic        clk;
    logic        reset;
    logic [19:0] Instr;
    logic [3:0]  ALUFlags;
    logic [1:0]  RegSrc;
    logic        RegWrite;
    logic [1:0]  ImmSrc;
    logic        ALUSrc;
    logic [1:0]  ALUControl;
    logic        MemtoReg;
    logic        MemWrite;
    logic        PCSrc;

    control_unit dut (
        .clk        (clk),
        .reset      (reset),
        .Instr      (Instr),
        .ALUFlags   (ALUFlags),
        .RegSrc     (RegSrc),
        .RegWrite   (RegWrite),
        .ImmSrc     (ImmSrc),
        .ALUSrc     (ALUSrc),
        .ALUControl (ALUControl),
        .MemtoReg   (MemtoReg),
        .MemWrite   (MemWrite),
        .PCSrc      (PCSrc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [10:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    localparam logic [3:0] C_EQ = 4'b0000;
    localparam logic [3:0] C_NE = 4'b0001;
    localparam logic [3:0] C_CS = 4'b0010;
    localparam logic [3:0] C_MI = 4'b0100;
    localparam logic [3:0] C_VS = 4'b0110;
    localparam logic [3:0] C_AL = 4'b1110;
    localparam logic [3:0] C_NV = 4'b1111;

    function automatic logic [19:0] mk(input logic [3:0] c, input logic [1:0] op,
                                       input logic [5:0] f, input logic [3:0] rd);
        return {c, op, f, 4'h0, rd};
    endfunction

    function automatic logic [10:0] ev(input logic [1:0] rs, input logic rw, input logic [1:0] imm,
                                       input logic as, input logic [1:0] alu, input logic m2r,
                                       input logic mw, input logic pc);
        return {rs, rw, imm, as, alu, m2r, mw, pc};
    endfunction

    task automatic step(input string name, input logic [19:0] ins, input logic [3:0] fl,
                        input logic [10:0] ex);
        exp_t e;
        @(posedge clk);
        #1;
        Instr    = ins;
        ALUFlags = fl;
        e.name   = name;
        e.exp    = ex;
        sb.push_back(e);
    endtask

    // Reads the registered flags through non-S ADDs conditioned on MI/EQ/CS/VS.
    // ALUFlags is driven to the complement so any spurious flag write is caught later.
    task automatic probe_flags(input string name, input logic [3:0] f);
        step({name, "_n"}, mk(C_MI, 2'b00, 6'b001000, 4'h1), ~f, ev(2'b00, f[3], 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0));
        step({name, "_z"}, mk(C_EQ, 2'b00, 6'b001000, 4'h1), ~f, ev(2'b00, f[2], 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0));
        step({name, "_c"}, mk(C_CS, 2'b00, 6'b001000, 4'h1), ~f, ev(2'b00, f[1], 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0));
        step({name, "_v"}, mk(C_VS, 2'b00, 6'b001000, 4'h1), ~f, ev(2'b00, f[0], 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0));
    endtask

    // Monitor: the DUT is combinational, so a pending entry is compared every falling edge.
    initial begin
        exp_t        e;
        logic [10:0] act;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e   = sb.pop_front();
                act = {RegSrc, RegWrite, ImmSrc, ALUSrc, ALUControl, MemtoReg, MemWrite, PCSrc};
                n_tests++;
                if (act !== e.exp) begin
                    n_fail++;
                    $display("FAIL %s: got %b expected %b", e.name, act, e.exp);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    localparam logic [10:0] E_NONE = 11'b0;

    initial begin
        reset    = 1'b0;
        Instr    = mk(C_AL, 2'b00, 6'b001000, 4'h1);
        ALUFlags = 4'b0000;
        repeat (3) @(posedge clk);
        #3 reset = 1'b1;

        // Flags are 0000 out of reset.
        step("rst_eq", mk(C_EQ, 2'b00, 6'b001000, 4'h1), 4'b0000, ev(2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0));
        step("rst_ne", mk(C_NE, 2'b00, 6'b001000, 4'h1), 4'b0000, ev(2'b00, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0));
        step("rst_al", mk(C_AL, 2'b00, 6'b001000, 4'h1), 4'b0000, ev(2'b00, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0));

        // ADDS R1, immediate.
        step("adds_imm", mk(C_AL, 2'b00, 6'b101001, 4'h1), 4'b0110, ev(2'b00, 1'b1, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0));
        probe_flags("adds_flags", 4'b0110);

        // CMP setting Z, then BEQ taken; CMP clearing Z, then BEQ not taken.
        step("cmp_z",     mk(C_AL, 2'b00, 6'b010101, 4'h0), 4'b0100, ev(2'b00, 1'b0, 2'b00, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0));
        step("beq_taken", mk(C_EQ, 2'b10, 6'b100000, 4'h0), 4'b0000, ev(2'b01, 1'b0, 2'b10, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1));
        step("cmp_nz",    mk(C_AL, 2'b00, 6'b010101, 4'h0), 4'b0000, ev(2'b00, 1'b0, 2'b00, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0));
        step("beq_not",   mk(C_EQ, 2'b10, 6'b100000, 4'h0), 4'b0100, ev(2'b01, 1'b0, 2'b10, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0));

        // Memory instructions.
        step("str", mk(C_AL, 2'b01, 6'b011000, 4'h2), 4'b0000, ev(2'b10, 1'b0, 2'b01, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0));
        step("ldr", mk(C_AL, 2'b01, 6'b011001, 4'h3), 4'b0000, ev(2'b00, 1'b1, 2'b01, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0));

        // SUBS sets C=V=1; ORRS then updates only N/Z.
        step("subs", mk(C_AL, 2'b00, 6'b000101, 4'h4), 4'b0011, ev(2'b00, 1'b1, 2'b00, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0));
        step("orrs", mk(C_AL, 2'b00, 6'b011001, 4'h4), 4'b1000, ev(2'b00, 1'b1, 2'b00, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0));
        probe_flags("orrs_flags", 4'b1011);

        // Failed condition must neither write the register nor the flags.
        step("cmp_set_z", mk(C_AL, 2'b00, 6'b010101, 4'h0), 4'b0100, ev(2'b00, 1'b0, 2'b00, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0));
        step("addne_s",   mk(C_NE, 2'b00, 6'b001001, 4'h5), 4'b1011, ev(2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0));
        probe_flags("addne_flags", 4'b0100);

        // Unsupported op, PC-destination DP, unsupported cmd with S, never-condition.
        step("op11",      mk(C_AL, 2'b11, 6'b111111, 4'hF), 4'b1111, E_NONE);
        step("add_pc",    mk(C_AL, 2'b00, 6'b001000, 4'hF), 4'b1111, ev(2'b00, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1));
        step("eor_unsup", mk(C_AL, 2'b00, 6'b000011, 4'h1), 4'b1111, E_NONE);
        step("cond_nv",   mk(C_NV, 2'b00, 6'b001000, 4'h1), 4'b1111, E_NONE);
        probe_flags("hold_flags", 4'b0100);

        // All flags set, then reset between edges.
        step("adds_ones", mk(C_AL, 2'b00, 6'b001001, 4'h1), 4'b1111, ev(2'b00, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0));
        probe_flags("ones_flags", 4'b1111);
        begin
            exp_t e;
            @(posedge clk);
            #1;
            Instr    = mk(C_EQ, 2'b00, 6'b001001, 4'h1);
            ALUFlags = 4'b1111;
            #1 reset = 1'b0;
            e.name = "rst_mid_eq";
            e.exp  = ev(2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
            sb.push_back(e);
        end
        probe_flags("rst_mid_flags", 4'b0000);
        @(posedge clk);
        #2 reset = 1'b1;
        step("post_rst_ne", mk(C_NE, 2'b00, 6'b001000, 4'h1), 4'b1111, ev(2'b00, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0));

        repeat (2) @(posedge clk);
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending entries expected 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_control_unit

// File: doc/control_unit.md
# control_unit

Single-cycle ARM-subset control unit that sits directly upstream of the datapath. It decodes Instr[31:12] into the datapath control strobes. It holds the NZCV condition flags in architectural state registers, fed by the datapath's ALUFlags. Every register, memory and PC write is qualified by the instruction's condition field, so only instructions whose condition passes commit state.

## Interface
Parameters:
- none (all encodings come from cpu_pkg)

Ports:
- clk  in  1  system clock, rising-edge active
- reset  in  1  asynchronous, active-low; clears flag state
- Instr  in  20  instruction bits [31:12]: Cond[31:28], Op[27:26], Funct[25:20], Rd[15:12]
- ALUFlags  in  4  current ALU flags {N,Z,C,V} = [3:0]
- RegSrc  out  2  [0]: RA1 = R15; [1]: RA2 = Rd
- RegWrite  out  1  register file write enable, condition-qualified
- ImmSrc  out  2  extend select: 00 imm8, 01 imm12, 10 imm24 branch
- ALUSrc  out  1  1: SrcB = ExtImm
- ALUControl  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR
- MemtoReg  out  1  1: Result = ReadData
- MemWrite  out  1  data memory write enable, condition-qualified
- PCSrc  out  1  1: PCNext = Result, condition-qualified

## Operation
Main decode, by Op:
- 00, DP: RegSrc=00, ImmSrc=00, ALUSrc=Funct[5], MemtoReg=0, RegW=1, MemW=0, Branch=0, ALUOp=1.
- 01, memory, Funct[0]=1 (LDR): RegSrc=00, ImmSrc=01, ALUSrc=1, MemtoReg=1, RegW=1, MemW=0, ALUOp=0.
- 01, Funct[0]=0 (STR): RegSrc=10, ImmSrc=01, ALUSrc=1, RegW=0, MemW=1, ALUOp=0.
- 10, B: RegSrc=01, ImmSrc=10, ALUSrc=1, RegW=0, MemW=0, Branch=1, ALUOp=0.
- 11, unsupported: RegW=MemW=Branch=0 and FlagW=00. All other outputs 0.

ALU decode:
- ALUOp=0 forces ADD.
- Otherwise decode cmd=Funct[4:1]: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR.
- 1010 CMP: SUB with RegW forced 0 and FlagW forced 11.
- Any other cmd: ALUControl=00, RegW=0, FlagW=00.

Flag write enables (S=Funct[0]):
- FlagW[1] = S; it enables the N and Z writes.
- FlagW[0] = S and ALUControl in {ADD, SUB}; it enables the C and V writes.
- FlagW = 00 when ALUOp=0.

Branch and write qualification:
- PCS = Branch | (RegW & Rd==4'hF).

Condition logic, evaluated on the registered flags:
- Conditions: EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL(1110). Standard ARM meaning for each.
- 1111 evaluates CondEx=0.
- RegWrite = RegW & CondEx; MemWrite = MemW & CondEx; PCSrc = PCS & CondEx.

Flag registers:
- FlagsNZ updates from ALUFlags[3:2] when FlagW[1] & CondEx.
- FlagsCV updates from ALUFlags[1:0] when FlagW[0] & CondEx.
- A failed condition never updates flags.

## Timing
- All control outputs are combinational from Instr and the flag registers. Zero-cycle latency.
- Flag registers update on the rising clk edge. The next instruction sees the new flags. The instruction that sets flags does not see its own result.
- Reset low asynchronously forces flags to 0000. While reset is low, outputs still decode Instr.
- Immediately after reset: EQ evaluates false, NE true, AL true.
- Reset asserted mid-cycle: flags clear at once and outputs re-evaluate combinationally. The in-flight flag update is lost.
- Same-edge flag write and read: the read uses the old value.
- When one S-instruction sets flags (logic op), C and V hold their prior values.

## Structure
- cpu_pkg holds:
  - enums op_t (DP, MEM, BR), cond_t (EQ…AL) and alu_ctrl_t (ADD, SUB, AND, ORR);
  - cmd constants (CMD_ADD, CMD_SUB, CMD_AND, CMD_ORR, CMD_CMP);
  - ImmSrc constants.
- One sub-module, cond_logic: holds the flag registers, the CondEx evaluation and the qualification gating.
- The decoder stays inline in control_unit.

## Test plan
- Reset low, then ADDS R1 (Instr=E29x..., Op=00, I=1, cmd 0100, S=1) with ALUFlags=0110 -> ALUSrc=1, ALUControl=00, RegWrite=1. After the edge, flags=0110.
- CMP with ALUFlags=0100, then BEQ (Cond=0000, Op=10) -> CMP: RegWrite=0. BEQ: PCSrc=1, ImmSrc=10, RegSrc=01. Repeat with ALUFlags=0000 -> PCSrc=0.
- STR (Op=01, Funct[0]=0, AL) -> MemWrite=1, RegWrite=0, RegSrc=10, ImmSrc=01. LDR -> MemtoReg=1, RegWrite=1, MemWrite=0.
- ORRS with flags C=1, V=1 preset by SUBS, ALUFlags=1000 -> after the edge, flags=1011 (C and V held).
- ADDNE with Z=1, S=1 -> RegWrite=0 and flags unchanged. Op=11 -> RegWrite=MemWrite=PCSrc=0.
- Flags=1111, pull reset low between edges -> flags read 0000 immediately. An EQ-conditioned ADD reads RegWrite=0 in the same cycle.
